multicycle_datapath: RTL and testbench

Datapath consumed directly by the multicycle RISC-V controller. It takes the controller's per-cycle control strobes and holds all architectural and inter-stage state: PC, old_pc, IR, MDR, A, B, ALUOut and a 32x32 register file. It also contains the immediate generator, the ALU with its ALU-control decode, and the memory address/data muxing. It drives `instr` back to the controller and presents a single-port memory interface.

---
 rtl/multicycle_datapath.sv | 218 +++++++++++++++++++++
 tb/tb_multicycle_datapath.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_datapath.sv
// multicycle_datapath
//
// Datapath half of a multicycle RV32I core. The controller drives one set of
// control strobes per cycle; this block holds all architectural and
// inter-stage state (pc, old_pc, ir, mdr, a, b, alu_out, 32x32 register file)
// and contains the immediate generator, ALU control decode, ALU and memory
// address/data muxing.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   PCWriteCondition, PCWrite  conditional / unconditional pc load
//   IorD                       mem_addr select: 0 = pc, 1 = alu_out
//   MemRead, MemWrite          memory strobes (gated off while reset = 1)
//   MemtoReg                   register write data: 0 = alu_out, 1 = mdr
//   IRWrite                    ir / old_pc load enable
//   PCSource                   pc next: 0 = ALU result, 1 = alu_out
//   ALUOp                      00 add, 01 sub, 10 funct decode, 11 add
//   ALUSrcA                    0 = pc (old_pc when ALUSrcB = 10), 1 = a
//   ALUSrcB                    00 = b, 01 = 4, 10/11 = immediate
//   RegWrite                   register file write enable
//   mem_rdata                  asynchronous memory read data
//   instr                      ir contents, back to the controller
//   zero                       ALU result == 0
//   mem_addr, mem_wdata        memory address / write data (write data = b)
//   mem_read, mem_write        gated memory strobes
//   pc                         current pc, for trace
//
// Handshake: there is none; the memory is a single-port array with
// combinational read, and every strobe is meaningful only in the cycle the
// controller asserts it.

module multicycle_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWriteCondition,
  input  logic        PCWrite,
  input  logic        IorD,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemtoReg,
  input  logic        IRWrite,
  input  logic        PCSource,
  input  logic [1:0]  ALUOp,
  input  logic        ALUSrcA,
  input  logic [1:0]  ALUSrcB,
  input  logic        RegWrite,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic        zero,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] pc
);

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  logic [31:0] old_pc;
  logic [31:0] ir;
  logic [31:0] mdr;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] alu_out;
  logic [31:0] rf [32];

  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] wb_data;
  logic [31:0] imm;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] alu_result;
  alu_op_e     alu_op;
  logic        pc_load;

  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign rd  = ir[11:7];

  // x0 is never written, but force zero on read so it never depends on that.
  assign rs1_data = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
  assign rs2_data = (rs2 == 5'd0) ? 32'd0 : rf[rs2];
  assign wb_data  = MemtoReg ? mdr : alu_out;

  assign instr     = ir;
  assign mem_addr  = IorD ? alu_out : pc;
  assign mem_wdata = b_q;
  assign mem_read  = MemRead & ~reset;
  assign mem_write = MemWrite & ~reset;

  // Immediate generator; anything not load/store/branch is treated as I-type.
  always_comb begin
    imm = {{20{ir[31]}}, ir[31:20]};
    case (ir[6:0])
      OPC_LOAD:   imm = {{20{ir[31]}}, ir[31:20]};
      OPC_STORE:  imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OPC_BRANCH: imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      default:    ;
    endcase
  end

  // ALU control decode.
  always_comb begin
    alu_op = ALU_ADD;
    case (ALUOp)
      2'b00: alu_op = ALU_ADD;
      2'b01: alu_op = ALU_SUB;
      2'b10: begin
        case (ir[14:12])
          3'b000: alu_op = ir[30] ? ALU_SUB : ALU_ADD;
          3'b001: alu_op = ALU_SLL;
          3'b010: alu_op = ALU_SLT;
          3'b011: alu_op = ALU_SLTU;
          3'b100: alu_op = ALU_XOR;
          3'b101: alu_op = ir[30] ? ALU_SRA : ALU_SRL;
          3'b110: alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
      end
      default: alu_op = ALU_ADD;
    endcase
  end

  // Operand A: in the branch-decode cycle (ALUSrcB = 10 with pc selected) the
  // target must be relative to the branch's own address, which is old_pc
  // because pc has already advanced past it during fetch.
  always_comb begin
    if (ALUSrcA)
      op_a = a_q;
    else if (ALUSrcB == 2'b10)
      op_a = old_pc;
    else
      op_a = pc;
  end

  always_comb begin
    case (ALUSrcB)
      2'b00:   op_b = b_q;
      2'b01:   op_b = 32'd4;
      default: op_b = imm;
    endcase
  end

  always_comb begin
    alu_result = 32'd0;
    case (alu_op)
      ALU_ADD:  alu_result = op_a + op_b;
      ALU_SUB:  alu_result = op_a - op_b;
      ALU_SLL:  alu_result = op_a << op_b[4:0];
      ALU_SLT:  alu_result = {31'd0, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: alu_result = {31'd0, op_a < op_b};
      ALU_XOR:  alu_result = op_a ^ op_b;
      ALU_SRL:  alu_result = op_a >> op_b[4:0];
      ALU_SRA:  alu_result = $signed(op_a) >>> op_b[4:0];
      ALU_OR:   alu_result = op_a | op_b;
      ALU_AND:  alu_result = op_a & op_b;
      default:  alu_result = 32'd0;
    endcase
  end

  assign zero    = (alu_result == 32'd0);
  assign pc_load = PCWrite | (PCWriteCondition & zero);

  // All state in one block so reset visibly overrides every enable,
  // including a pending register-file write.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= RESET_PC;
      old_pc  <= 32'd0;
      ir      <= 32'd0;
      mdr     <= 32'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      alu_out <= 32'd0;
      for (int i = 0; i < 32; i++) begin
        rf[i] <= 32'd0;
      end
    end else begin
      mdr     <= mem_rdata;
      a_q     <= rs1_data;
      b_q     <= rs2_data;
      alu_out <= alu_result;
      if (IRWrite) begin
        ir     <= mem_rdata;
        old_pc <= pc;
      end
      if (pc_load) begin
        pc <= PCSource ? alu_out : alu_result;
      end
      // No bypass: a read in the same cycle sees the pre-write value.
      if (RegWrite && (rd != 5'd0)) begin
        rf[rd] <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_datapath.sv
// tb_multicycle_datapath
//
// Drives multicycle_datapath through hand-sequenced controller strobes.
// Register contents are observed through mem_wdata (b is loaded from
// rf[ir[24:20]] every cycle), alu_out through mem_addr with IorD = 1.

module tb_multicycle_datapath;

  logic        clk;
  logic        reset;
  logic        PCWriteCondition;
  logic        PCWrite;
  logic        IorD;
  logic        MemRead;
  logic        MemWrite;
  logic        MemtoReg;
  logic        IRWrite;
  logic        PCSource;
  logic [1:0]  ALUOp;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic        RegWrite;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic        zero;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] pc;

  multicycle_datapath #(.RESET_PC(32'h0000_0000)) dut (
    .clk              (clk),
    .reset            (reset),
    .PCWriteCondition (PCWriteCondition),
    .PCWrite          (PCWrite),
    .IorD             (IorD),
    .MemRead          (MemRead),
    .MemWrite         (MemWrite),
    .MemtoReg         (MemtoReg),
    .IRWrite          (IRWrite),
    .PCSource         (PCSource),
    .ALUOp            (ALUOp),
    .ALUSrcA          (ALUSrcA),
    .ALUSrcB          (ALUSrcB),
    .RegWrite         (RegWrite),
    .mem_rdata        (mem_rdata),
    .instr            (instr),
    .zero             (zero),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .pc               (pc)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic [31:0] rf_model [32];
  logic [31:0] exp_pc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic push_exp(input string tag, input logic [31:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic pop_cmp(input logic [31:0] got);
    logic [31:0] e;
    string       t;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, got, e);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    PCWriteCondition = 1'b0;
    PCWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 1'b0;
    IRWrite  = 1'b0;
    PCSource = 1'b0;
    ALUOp    = 2'b00;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    RegWrite = 1'b0;
    mem_rdata = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] ins, input bit inc);
    idle();
    mem_rdata = ins;
    IRWrite   = 1'b1;
    MemRead   = 1'b1;
    if (inc) begin
      PCWrite = 1'b1;
      ALUSrcB = 2'b01;
    end
    tick();
    if (inc) exp_pc = exp_pc + 32'd4;
    idle();
  endtask

  // Register read-back: fetch an R-type word whose rs2 field is idx; after
  // one more edge b (and so mem_wdata) holds rf[idx].
  task automatic read_reg(input logic [4:0] idx);
    push_exp($sformatf("x%0d", idx), rf_model[idx]);
    fetch({7'd0, idx, 5'd0, 3'b000, 5'd0, 7'b0110011}, 1'b0);
    tick();
    pop_cmp(mem_wdata);
  endtask

  // lw rd, 0(x0) with the memory returning val.
  task automatic load_reg(input logic [4:0] rd, input logic [31:0] val);
    fetch({12'd0, 5'd0, 3'b010, rd, 7'b0000011}, 1'b0);
    tick();
    ALUSrcA = 1'b1;
    ALUSrcB = 2'b10;
    tick();
    idle();
    IorD      = 1'b1;
    MemRead   = 1'b1;
    mem_rdata = val;
    tick();
    idle();
    RegWrite = 1'b1;
    MemtoReg = 1'b1;
    tick();
    idle();
    if (rd != 5'd0) rf_model[rd] = val;
  endtask

  task automatic run_r(input logic [31:0] ins);
    fetch(ins, 1'b0);
    tick();
    ALUSrcA = 1'b1;
    ALUSrcB = 2'b00;
    ALUOp   = 2'b10;
    tick();
    idle();
    RegWrite = 1'b1;
    tick();
    idle();
  endtask

  function automatic logic [31:0] alu_model(input logic [2:0] f3, input logic f7,
                                            input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (f3)
      3'b000: r = f7 ? a - b : a + b;
      3'b001: r = a << b[4:0];
      3'b010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b011: r = (a < b) ? 32'd1 : 32'd0;
      3'b100: r = a ^ b;
      3'b101: r = f7 ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'b110: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] ra, rb, res;
    logic [2:0]  f3;
    logic        f7;

    idle();
    reset = 1'b1;
    for (int i = 0; i < 32; i++) rf_model[i] = 32'd0;
    exp_pc = 32'd0;

    // Reset held two cycles while enables try to act.
    PCWrite  = 1'b1;
    RegWrite = 1'b1;
    MemRead  = 1'b1;
    MemWrite = 1'b1;
    #1;
    check("rst_mem_read", {31'd0, mem_read}, 32'd0);
    check("rst_mem_write", {31'd0, mem_write}, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    idle();
    #1;
    check("rst_pc", pc, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    read_reg(5'd1);
    read_reg(5'd31);

    // Fetch of lw x1,8(x0) with pc increment.
    idle();
    mem_rdata = 32'h0080_2083;
    IRWrite = 1'b1;
    PCWrite = 1'b1;
    ALUSrcB = 2'b01;
    MemRead = 1'b1;
    #1;
    check("fetch_mem_read", {31'd0, mem_read}, 32'd1);
    check("fetch_mem_addr", mem_addr, 32'd0);
    tick();
    exp_pc = 32'd4;
    check("fetch_pc", pc, 32'd4);
    check("fetch_instr", instr, 32'h0080_2083);

    // lw x1,8(x0): decode, address, memory, writeback.
    idle();
    tick();
    ALUSrcA = 1'b1;
    ALUSrcB = 2'b10;
    tick();
    idle();
    IorD = 1'b1;
    MemRead = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    #1;
    check("lw_mem_addr", mem_addr, 32'd8);
    tick();
    idle();
    RegWrite = 1'b1;
    MemtoReg = 1'b1;
    tick();
    idle();
    rf_model[1] = 32'hDEAD_BEEF;
    read_reg(5'd1);

    // sub / add x3,x1,x2 with x1=5, x2=7.
    load_reg(5'd1, 32'd5);
    load_reg(5'd2, 32'd7);
    run_r(32'h4020_81B3);
    rf_model[3] = 32'hFFFF_FFFE;
    read_reg(5'd3);
    run_r(32'h0020_81B3);
    rf_model[3] = 32'd12;
    read_reg(5'd3);

    // sw x2,-8(x1): S-type immediate, store strobe and data.
    fetch(32'hFE20_AC23, 1'b0);
    tick();
    ALUSrcA = 1'b1;
    ALUSrcB = 2'b10;
    tick();
    idle();
    IorD = 1'b1;
    MemWrite = 1'b1;
    #1;
    check("sw_addr", mem_addr, 32'hFFFF_FFFD);
    check("sw_wdata", mem_wdata, 32'd7);
    check("sw_mem_write", {31'd0, mem_write}, 32'd1);
    tick();
    idle();

    // beq x0,x0,+16 fetched at pc=8: taken.
    fetch(32'h0000_0013, 1'b1);
    check("pc_before_beq", pc, 32'd8);
    fetch(32'h0000_0863, 1'b1);
    ALUSrcB = 2'b10;
    tick();
    idle();
    ALUOp = 2'b01;
    ALUSrcA = 1'b1;
    PCWriteCondition = 1'b1;
    PCSource = 1'b1;
    IorD = 1'b1;
    #1;
    check("beq_target", mem_addr, 32'd24);
    check("beq_zero_taken", {31'd0, zero}, 32'd1);
    tick();
    idle();
    exp_pc = 32'd24;
    check("beq_pc_taken", pc, exp_pc);

    // beq x5,x7,+16 with 5 != 7: not taken.
    load_reg(5'd5, 32'd5);
    load_reg(5'd7, 32'd7);
    fetch(32'h0072_8863, 1'b1);
    ALUSrcB = 2'b10;
    tick();
    idle();
    ALUOp = 2'b01;
    ALUSrcA = 1'b1;
    PCWriteCondition = 1'b1;
    PCSource = 1'b1;
    IorD = 1'b1;
    #1;
    check("bne_target", mem_addr, 32'd40);
    check("beq_zero_not_taken", {31'd0, zero}, 32'd0);
    tick();
    idle();
    check("beq_pc_not_taken", pc, 32'd28);

    // addi x0,x0,0x55: ALUOut=0x55 but x0 must stay 0.
    fetch(32'h0550_0013, 1'b0);
    tick();
    ALUSrcA = 1'b1;
    ALUSrcB = 2'b10;
    tick();
    idle();
    IorD = 1'b1;
    RegWrite = 1'b1;
    #1;
    check("x0_aluout", mem_addr, 32'h55);
    tick();
    idle();
    read_reg(5'd0);

    // Random R-type operations against the bench ALU model.
    for (int i = 0; i < 10; i++) begin
      ra = $urandom();
      rb = $urandom();
      if (i == 0) rb = 32'd0;
      f3 = 3'($urandom_range(0, 7));
      f7 = 1'($urandom_range(0, 1));
      res = alu_model(f3, f7, ra, rb);
      load_reg(5'd1, ra);
      load_reg(5'd2, rb);
      run_r({1'b0, f7, 5'd0, 5'd2, 5'd1, f3, 5'd3, 7'b0110011});
      rf_model[3] = res;
      read_reg(5'd3);
    end

    // Reset during the memory cycle of lw x1,8(x0), with a writeback pending.
    fetch(32'h0080_2083, 1'b1);
    tick();
    ALUSrcA = 1'b1;
    ALUSrcB = 2'b10;
    tick();
    idle();
    IorD = 1'b1;
    MemRead = 1'b1;
    mem_rdata = 32'h1234_5678;
    RegWrite = 1'b1;
    MemtoReg = 1'b1;
    PCWrite = 1'b1;
    reset = 1'b1;
    #1;
    check("midrst_mem_read", {31'd0, mem_read}, 32'd0);
    tick();
    reset = 1'b0;
    idle();
    for (int i = 0; i < 32; i++) rf_model[i] = 32'd0;
    exp_pc = 32'd0;
    #1;
    check("midrst_pc", pc, exp_pc);
    check("midrst_instr", instr, 32'd0);
    check("midrst_mem_addr", mem_addr, 32'd0);
    read_reg(5'd1);
    read_reg(5'd3);

    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
